freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Measures an external/divided square wave; the counterpart of the clock divider, recovering the toggle rate instead of generating it.
- Counts rising edges of SIG_IN over a fixed gate window of GATE_CYCLES sCLK cycles.
- Publishes the count on FREQ with a one-cycle VALID strobe.
- Feeds the display/UART path and the self-check of divided clocks.

Parameters:
- GATE_CYCLES, 50000000, gate window length in sCLK cycles (1 s at 50 MHz); must be >= 4.
- CNT_W, 32, width of the edge counter and FREQ.

Ports:
- sCLK  input  1  system clock; all logic on its posedge.
- RESET  input  1  synchronous, active-low reset (0 = reset), sampled on posedge sCLK.
- EN  input  1  1 = measure continuously; 0 = go idle.
- SIG_IN  input  1  asynchronous signal under measurement.
- FREQ  output  CNT_W  rising-edge count of the last completed window.
- VALID  output  1  one-cycle pulse when FREQ updates.
- OVF  output  1  last completed window saturated the edge counter.
- BUSY  output  1  high while a window is in progress.

Behaviour:
- Reset (RESET=0 at posedge):
  - FREQ=0, VALID=0, OVF=0, BUSY=0.
  - Synchronizer flops, edge register and counters cleared.
  - State=IDLE.
  - Reset mid-window discards the partial count; FREQ is not updated.
- Input path:
  - 2-flop synchronizer, then a delay flop.
  - edge = sync2 & ~dly.
  - Latency from a SIG_IN rise to edge: 3 sCLK cycles.
- FSM states: IDLE, ARM, MEASURE.
- IDLE:
  - BUSY=0, counters held at 0.
  - EN=1 -> ARM.
- ARM:
  - Single cycle; loads dly from sync2 so a level already high is not counted as an edge.
  - EN=1 -> MEASURE with gate_cnt=0, edge_cnt=0.
  - EN=0 -> IDLE.
- MEASURE:
  - BUSY=1.
  - gate_cnt increments each cycle from 0 to GATE_CYCLES-1.
  - edge_cnt increments on edge, saturating at 2^CNT_W-1; the saturation sets a sticky window-overflow flag.
- Terminal cycle (gate_cnt == GATE_CYCLES-1):
  - FREQ <= edge_cnt + edge, saturated.
  - OVF <= window-overflow flag, including overflow caused by this cycle's edge.
  - VALID <= 1 on the next cycle only.
  - gate_cnt <= 0, edge_cnt <= 0, flag cleared.
  - Stay in MEASURE if EN=1, else -> IDLE.
- Edge counting is continuous across back-to-back windows:
  - An edge on the terminal cycle counts in the closing window.
  - An edge on the following cycle counts in the new window.
- EN deassertion:
  - EN=0 during MEASURE before the terminal cycle -> IDLE immediately.
  - The partial window is dropped; FREQ, OVF and VALID are unchanged.
- Stale outputs:
  - FREQ and OVF hold their values between updates and in IDLE.
  - VALID is never high for two consecutive cycles.
- Arithmetic:
  - gate_cnt width = clog2(GATE_CYCLES).
  - All compares are unsigned.
  - No wrap-around of edge_cnt; it saturates.
- Maximum countable edge rate: sCLK/2. A SIG_IN high or low phase shorter than one sCLK cycle may be missed; not an error.

Optional Feature:
- Macro: FREQ_METER_PERIOD_EN.
- Defined:
  - Adds output PERIOD [CNT_W-1:0], reset 0.
  - A free-running counter restarts to 1 on each edge while BUSY.
  - On each edge after the first in the current EN session, PERIOD <= counter value, i.e. sCLK cycles between the last two edges.
  - PERIOD saturates at all-ones.
  - PERIOD is cleared to 0 on entry to IDLE.
- Not defined: no PERIOD port and no period logic; all other behaviour identical.

Test Plan:
- Bench parameters: GATE_CYCLES=100, CNT_W=8.
- SIG_IN period 10 cycles (5 high / 5 low), EN=1 from reset release -> first VALID after 2+100 cycles; FREQ=10, OVF=0; VALID every 100 cycles thereafter.
- SIG_IN held 1 before EN rises, no further toggles -> FREQ=0 (ARM suppresses the false edge).
- SIG_IN period 2 (toggle every cycle) -> FREQ=50. Then GATE_CYCLES=600 with period 2 -> counter saturates, FREQ=255, OVF=1. Next window at period 10 -> FREQ=60, OVF=0.
- Edge placed exactly on terminal cycle and one on the following cycle -> each counted once, in consecutive windows; total across windows equals edges driven.
- EN=0 at gate_cnt=40 -> no VALID, FREQ keeps prior value, BUSY=0 next cycle. RESET=0 at gate_cnt=70 -> FREQ=0, VALID=0, state IDLE.
- With FREQ_METER_PERIOD_EN, SIG_IN period 7 -> PERIOD=7 after second edge and stable; EN=0 -> PERIOD=0.

Source files
------------

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//   Counts rising edges of an asynchronous square wave over a fixed window of
//   GATE_CYCLES sCLK cycles. At the end of each window the count is published
//   on FREQ together with a one-cycle VALID strobe. This is the inverse of the
//   clock divider: it recovers a toggle rate instead of generating one.
//
//   Optional build macro: FREQ_METER_PERIOD_EN
//     When defined, the PERIOD output is added. It reports the number of sCLK
//     cycles between the last two detected edges.
//
// Parameters
//   GATE_CYCLES : window length in sCLK cycles (>= 4)
//   CNT_W       : width of the edge counter, FREQ and PERIOD
//
// Ports
//   sCLK   : system clock, all logic on its rising edge
//   RESET  : synchronous reset, active low
//   EN     : 1 = measure continuously, 0 = go idle
//   SIG_IN : asynchronous signal under measurement
//   FREQ   : rising-edge count of the last completed window
//   VALID  : one-cycle pulse when FREQ/OVF update
//   OVF    : last completed window saturated the edge counter
//   BUSY   : a window is in progress
//   PERIOD : (FREQ_METER_PERIOD_EN only) sCLK cycles between the last two edges
// -----------------------------------------------------------------------------
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32
) (
  input  logic             sCLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             SIG_IN,
  output logic [CNT_W-1:0] FREQ,
  output logic             VALID,
  output logic             OVF,
  output logic             BUSY
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_W-1:0] PERIOD
`endif
);

  localparam int              GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic             sync1_reg, sync2_reg, dly_reg, edge_reg;
  logic [GW-1:0]    gate_cnt_reg;
  logic [CNT_W-1:0] edge_cnt_reg;
  logic             wovf_reg;
  logic [CNT_W-1:0] freq_reg;
  logic             valid_reg, ovf_reg;

  logic [CNT_W:0]   edge_sum;
  logic             edge_sat;
  logic [CNT_W-1:0] edge_cnt_next;
  logic             terminal;

  // Extra MSB of the sum exposes the carry-out, which is exactly the case
  // where an edge arrives while the counter already holds all-ones.
  assign edge_sum      = {1'b0, edge_cnt_reg} + {{CNT_W{1'b0}}, edge_reg};
  assign edge_sat      = edge_sum[CNT_W];
  assign edge_cnt_next = edge_sat ? CNT_MAX : edge_sum[CNT_W-1:0];
  assign terminal      = (state_reg == MEASURE) && (gate_cnt_reg == GATE_LAST);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge sCLK) begin
    if (!RESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Dropping EN in MEASURE leaves immediately. On the terminal cycle, the
  // datapath still publishes the closing window.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (EN) state_next = ARM;
      ARM:     state_next = EN ? MEASURE : IDLE;
      MEASURE: if (!EN) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Input path and window datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge sCLK) begin
    if (!RESET) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      dly_reg      <= 1'b0;
      edge_reg     <= 1'b0;
      gate_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      wovf_reg     <= 1'b0;
      freq_reg     <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      sync1_reg <= SIG_IN;
      sync2_reg <= sync1_reg;
      // dly tracks sync2 in every state. Therefore, by the end of ARM a level
      // that was already high matches sync2 and does not look like a rising
      // edge in the first MEASURE cycle.
      dly_reg   <= sync2_reg;
      edge_reg  <= (state_reg != IDLE) & sync2_reg & ~dly_reg;
      valid_reg <= 1'b0;

      if (terminal) begin
        // This cycle's edge belongs to the closing window.
        freq_reg     <= edge_cnt_next;
        ovf_reg      <= wovf_reg | edge_sat;
        valid_reg    <= 1'b1;
        gate_cnt_reg <= '0;
        edge_cnt_reg <= '0;
        wovf_reg     <= 1'b0;
      end else if ((state_reg == MEASURE) && EN) begin
        gate_cnt_reg <= gate_cnt_reg + GW'(1);
        edge_cnt_reg <= edge_cnt_next;
        wovf_reg     <= wovf_reg | edge_sat;
      end else begin
        // IDLE, ARM, or an abandoned window: the partial count is discarded.
        gate_cnt_reg <= '0;
        edge_cnt_reg <= '0;
        wovf_reg     <= 1'b0;
      end
    end
  end

  assign FREQ  = freq_reg;
  assign VALID = valid_reg;
  assign OVF   = ovf_reg;
  assign BUSY  = (state_reg == MEASURE);

`ifdef FREQ_METER_PERIOD_EN
  // ---------------------------------------------------------------------------
  // Edge-to-edge period measurement
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] per_cnt_reg, period_reg;
  logic             seen_reg;

  always_ff @(posedge sCLK) begin
    if (!RESET) begin
      per_cnt_reg <= '0;
      period_reg  <= '0;
      seen_reg    <= 1'b0;
    end else if (state_next == IDLE) begin
      per_cnt_reg <= '0;
      period_reg  <= '0;
      seen_reg    <= 1'b0;
    end else if (state_reg == MEASURE) begin
      if (edge_reg) begin
        // The first edge of a session only starts the count, because there is
        // no earlier edge to measure against.
        per_cnt_reg <= CNT_W'(1);
        seen_reg    <= 1'b1;
        if (seen_reg) begin
          period_reg <= per_cnt_reg;
        end
      end else if (per_cnt_reg != CNT_MAX) begin
        per_cnt_reg <= per_cnt_reg + CNT_W'(1);
      end
    end else begin
      per_cnt_reg <= '0;
      seen_reg    <= 1'b0;
    end
  end

  assign PERIOD = period_reg;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
//   Directed bench for freq_meter with CNT_W=8.
//   u0 uses GATE_CYCLES=100 and u1 uses GATE_CYCLES=600, which exercises
//   counter saturation.
//   Expected window results are queued when the stimulus is set up. They are
//   checked against the DUT each time its VALID strobe fires.
// -----------------------------------------------------------------------------
module tb_freq_meter;

  logic       sCLK = 1'b0;
  logic       RESET, en0, sig0, en1, sig1;
  logic [7:0] freq0, freq1;
  logic       valid0, valid1, ovf0, ovf1, busy0, busy1;
`ifdef FREQ_METER_PERIOD_EN
  logic [7:0] period0, period1;
`endif

  always #5 sCLK = ~sCLK;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8)) u0 (
    .sCLK(sCLK), .RESET(RESET), .EN(en0), .SIG_IN(sig0),
    .FREQ(freq0), .VALID(valid0), .OVF(ovf0), .BUSY(busy0)
`ifdef FREQ_METER_PERIOD_EN
    , .PERIOD(period0)
`endif
  );

  freq_meter #(.GATE_CYCLES(600), .CNT_W(8)) u1 (
    .sCLK(sCLK), .RESET(RESET), .EN(en1), .SIG_IN(sig1),
    .FREQ(freq1), .VALID(valid1), .OVF(ovf1), .BUSY(busy1)
`ifdef FREQ_METER_PERIOD_EN
    , .PERIOD(period1)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Scoreboards: each entry is {ovf, freq}.
  logic [8:0] exp0_q[$];
  logic [8:0] exp1_q[$];
  logic [8:0] e0, e1;
  logic       pv0 = 1'b0, pv1 = 1'b0;

  // Square-wave generators. A period of 0 holds the current level.
  int per0 = 0, ph0 = 0, per1 = 0, ph1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sCLK);
      if (per0 != 0) begin
        sig0 = (ph0 < per0 / 2);
        ph0  = (ph0 + 1) % per0;
      end
      if (per1 != 0) begin
        sig1 = (ph1 < per1 / 2);
        ph1  = (ph1 + 1) % per1;
      end
    end
  endtask

  // VALID monitors: every strobe must match a queued expectation. A strobe
  // must also never follow another strobe on the previous cycle.
  always @(negedge sCLK) begin
    if (RESET === 1'b1 && valid0 === 1'b1) begin
      check("u0_valid_gap", {31'd0, pv0}, 32'd0);
      check("u0_valid_expected", exp0_q.size(), 32'd1 + ((exp0_q.size() > 1) ? exp0_q.size() - 1 : 0));
      if (exp0_q.size() != 0) begin
        e0 = exp0_q.pop_front();
        $display("u0 window: freq=%0d ovf=%0d expected freq=%0d ovf=%0d", freq0, ovf0, e0[7:0], e0[8]);
        check("u0_freq", {24'd0, freq0}, {24'd0, e0[7:0]});
        check("u0_ovf", {31'd0, ovf0}, {31'd0, e0[8]});
      end
    end
    pv0 = valid0;
  end

  always @(negedge sCLK) begin
    if (RESET === 1'b1 && valid1 === 1'b1) begin
      check("u1_valid_gap", {31'd0, pv1}, 32'd0);
      check("u1_valid_expected", exp1_q.size(), 32'd1 + ((exp1_q.size() > 1) ? exp1_q.size() - 1 : 0));
      if (exp1_q.size() != 0) begin
        e1 = exp1_q.pop_front();
        $display("u1 window: freq=%0d ovf=%0d expected freq=%0d ovf=%0d", freq1, ovf1, e1[7:0], e1[8]);
        check("u1_freq", {24'd0, freq1}, {24'd0, e1[7:0]});
        check("u1_ovf", {31'd0, ovf1}, {31'd0, e1[8]});
      end
    end
    pv1 = valid1;
  end

  initial begin
    RESET = 1'b0; en0 = 1'b0; sig0 = 1'b0; en1 = 1'b0; sig1 = 1'b0;
    tick(4);
    check("rst_freq", {24'd0, freq0}, 32'd0);
    check("rst_valid", {31'd0, valid0}, 32'd0);
    check("rst_ovf", {31'd0, ovf0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);

    // Period 10 from reset release: three windows of 10 edges each.
    // The first VALID appears 2+100 cycles after release.
    per0 = 10; ph0 = 0;
    repeat (3) exp0_q.push_back({1'b0, 8'd10});
    RESET = 1'b1; en0 = 1'b1;
    tick(101);
    check("first_valid_early", {31'd0, valid0}, 32'd0);
    check("busy_measure", {31'd0, busy0}, 32'd1);
    tick(1);
    check("first_valid_time", {31'd0, valid0}, 32'd1);
    tick(99);
    check("second_valid_early", {31'd0, valid0}, 32'd0);
    tick(1);
    check("second_valid_time", {31'd0, valid0}, 32'd1);
    tick(100);
    check("third_valid_time", {31'd0, valid0}, 32'd1);
    en0 = 1'b0;
    tick(1);
    check("idle_busy", {31'd0, busy0}, 32'd0);
    check("idle_freq_hold", {24'd0, freq0}, 32'd10);

    // Dropping EN at gate_cnt=40 abandons the window with no VALID.
    en0 = 1'b1;
    tick(42);
    en0 = 1'b0;
    tick(1);
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_valid", {31'd0, valid0}, 32'd0);
    tick(5);
    check("abort_freq_hold", {24'd0, freq0}, 32'd10);

    // A level already high when EN rises must not count as an edge.
    per0 = 0; sig0 = 1'b1;
    tick(5);
    exp0_q.push_back({1'b0, 8'd0});
    en0 = 1'b1;
    tick(102);
    check("held_high_valid", {31'd0, valid0}, 32'd1);
    en0 = 1'b0; sig0 = 1'b0;
    tick(3);

    // Toggling every cycle (the maximum rate) gives 50 edges per window.
    per0 = 2; ph0 = 0;
    tick(6);
    exp0_q.push_back({1'b0, 8'd50});
    en0 = 1'b1;
    tick(102);
    en0 = 1'b0;
    tick(3);

    // Window boundaries. An edge on window 1's terminal cycle counts in
    // window 1. An edge on window 3's first cycle counts in window 3.
    // Three edges are driven in total, so the window counts are 2 + 0 + 1.
    per0 = 0; sig0 = 1'b0;
    tick(3);
    exp0_q.push_back({1'b0, 8'd2});
    exp0_q.push_back({1'b0, 8'd0});
    exp0_q.push_back({1'b0, 8'd1});
    en0 = 1'b1;
    tick(20);  sig0 = 1'b1; tick(2); sig0 = 1'b0;
    tick(76);  sig0 = 1'b1; tick(2); sig0 = 1'b0;
    tick(99);  sig0 = 1'b1; tick(2); sig0 = 1'b0;
    tick(101);
    check("boundary_valid3", {31'd0, valid0}, 32'd1);
    en0 = 1'b0;
    tick(3);

    // Reset at gate_cnt=70: the partial count is dropped and FREQ clears.
    per0 = 10; ph0 = 0;
    en0 = 1'b1;
    tick(72);
    RESET = 1'b0;
    tick(1);
    check("midrst_freq", {24'd0, freq0}, 32'd0);
    check("midrst_valid", {31'd0, valid0}, 32'd0);
    check("midrst_busy", {31'd0, busy0}, 32'd0);
    check("midrst_ovf", {31'd0, ovf0}, 32'd0);
    RESET = 1'b1; en0 = 1'b0; per0 = 0; sig0 = 1'b0;
    tick(3);
    check("post_rst_busy", {31'd0, busy0}, 32'd0);

    // 600-cycle window at period 2 saturates at 255 with OVF set. The signal
    // then switches to period 10, giving 60 edges and clearing OVF.
    per1 = 2; ph1 = 0;
    exp1_q.push_back({1'b1, 8'd255});
    exp1_q.push_back({1'b0, 8'd60});
    en1 = 1'b1;
    tick(550);
    per1 = 10; ph1 = 0;
    tick(52);
    check("sat_valid", {31'd0, valid1}, 32'd1);
    tick(600);
    check("recover_valid", {31'd0, valid1}, 32'd1);
    en1 = 1'b0;
    tick(3);
    check("recover_ovf_hold", {31'd0, ovf1}, 32'd0);

`ifdef FREQ_METER_PERIOD_EN
    // Period 7 signal: PERIOD reads 7 once two edges are seen. It clears to 0
    // on return to IDLE.
    per0 = 7; ph0 = 0;
    en0 = 1'b1;
    tick(40);
    check("period_7", {24'd0, period0}, 32'd7);
    tick(8);
    check("period_7_stable", {24'd0, period0}, 32'd7);
    en0 = 1'b0;
    tick(3);
    check("period_idle_clear", {24'd0, period0}, 32'd0);
    per0 = 0; sig0 = 1'b0;
    tick(2);
`endif

    check("u0_queue_drained", exp0_q.size(), 32'd0);
    check("u1_queue_drained", exp1_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
